// File: rtl/grf_pkg.sv
// Shared GRF constants and the saturating write-counter helper used by the
// writeback arbiter.
package grf_pkg;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_DATA_W = 32;
  localparam logic [GRF_ADDR_W-1:0] GRF_ZERO_REG = 5'd0;
  localparam int WB_CNT_W = 16;
  localparam logic [WB_CNT_W-1:0] WB_CNT_MAX = '1;

  function automatic logic [WB_CNT_W-1:0] wb_cnt_inc(input logic [WB_CNT_W-1:0] v);
    return (v == WB_CNT_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr, wrapping modulo N, wins.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);
  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/grf_wb_arbiter.sv
// Round-robin arbiter sharing the GRF write port among N_REQ writeback sources.
// Optional build macro GRF_WB_ZERO_DROP_EN: $0 writes are acked and discarded.
module grf_wb_arbiter
  import grf_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int DATA_W = GRF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ADDR_W-1:0]  req_rw,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     wb_stall,
  output logic [ADDR_W-1:0]        RW,
  output logic [DATA_W-1:0]        busW,
  output logic                     RegWrite,
  output logic [WB_CNT_W-1:0]      wb_count
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]    arb_req, gnt;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_vld;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]   rw_q, rw_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_q, we_d;
  logic [WB_CNT_W-1:0] cnt_q, cnt_d;

`ifdef GRF_WB_ZERO_DROP_EN
  logic [N_REQ-1:0] zero_req;
  for (genvar i = 0; i < N_REQ; i++) begin : g_zero
    assign zero_req[i] = (req_rw[i*ADDR_W +: ADDR_W] == ADDR_W'(GRF_ZERO_REG));
  end
  // $0 requests bypass arbitration and are acked even under stall.
  assign arb_req   = (reset || wb_stall) ? '0 : (req_valid & ~zero_req);
  assign req_ready = reset ? '0 : (gnt | (req_valid & zero_req));
`else
  assign arb_req   = (reset || wb_stall) ? '0 : req_valid;
  assign req_ready = gnt;
`endif

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    ptr_d  = ptr_q;
    rw_d   = rw_q;
    data_d = data_q;
    we_d   = we_q;
    cnt_d  = cnt_q;
    // A presented write commits on any unstalled cycle.
    if (!wb_stall) begin
      if (we_q) cnt_d = wb_cnt_inc(cnt_q);
      we_d = gnt_vld;
      if (gnt_vld) begin
        rw_d   = req_rw[gnt_idx*ADDR_W +: ADDR_W];
        data_d = req_data[gnt_idx*DATA_W +: DATA_W];
        ptr_d  = (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      rw_q   <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      rw_q   <= rw_d;
      data_q <= data_d;
      we_q   <= we_d;
      cnt_q  <= cnt_d;
    end
  end

  assign RW       = rw_q;
  assign busW     = data_q;
  assign RegWrite = we_q;
  assign wb_count = cnt_q;
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_grf_wb_arbiter;
  localparam int N = 3;
`ifdef GRF_WB_ZERO_DROP_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*5-1:0]  req_rw;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          wb_stall;
  logic [4:0]    RW;
  logic [31:0]   busW;
  logic          RegWrite;
  logic [15:0]   wb_count;

  logic [4:0]  t_rw [N];
  logic [31:0] t_d  [N];

  assign req_rw   = {t_rw[2], t_rw[1], t_rw[0]};
  assign req_data = {t_d[2], t_d[1], t_d[0]};

  always #5 clk = ~clk;

  grf_wb_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
    .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
    .RW(RW), .busW(busW), .RegWrite(RegWrite), .wb_count(wb_count)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (%0d): got %0h expected %0h", nm, tag, act, exp);
  endtask

  // Behavioural model: pointer, presented write and commit count.
  int         m_ptr;
  bit         m_we;
  logic [4:0] m_rw;
  logic [31:0] m_d;
  int         m_cnt;

  function automatic bit is_drop(input int i);
    return ZD && (t_rw[i] == 5'd0);
  endfunction

  function automatic int m_winner();
    int w = -1;
    if (reset || wb_stall) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (w < 0 && req_valid[i] && !is_drop(i)) w = i;
    end
    return w;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r = '0;
    int w;
    if (reset) return '0;
    for (int i = 0; i < N; i++) if (req_valid[i] && is_drop(i)) r[i] = 1'b1;
    w = m_winner();
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic m_step();
    int w;
    if (reset) begin
      m_ptr = 0; m_we = 0; m_rw = 0; m_d = 0; m_cnt = 0;
    end else if (!wb_stall) begin
      w = m_winner();
      if (m_we && m_cnt < 65535) m_cnt++;
      m_we = (w >= 0);
      if (w >= 0) begin
        m_rw = t_rw[w]; m_d = t_d[w]; m_ptr = (w + 1) % N;
      end
    end
  endtask

  task automatic model_check(input int tag);
    chk("rnd_ready", tag, 32'(req_ready), 32'(m_ready()));
    chk("rnd_we", tag, 32'(RegWrite), 32'(m_we));
    if (m_we) begin
      chk("rnd_rw", tag, 32'(RW), 32'(m_rw));
      chk("rnd_busW", tag, busW, m_d);
    end
    chk("rnd_cnt", tag, 32'(wb_count), 32'(m_cnt));
  endtask

  // Inputs stay put across the negedge check and the posedge capture.
  task automatic cyc(input bit mchk, input int tag, output logic [N-1:0] er);
    @(negedge clk);
    if (mchk) model_check(tag);
    @(posedge clk);
    er = m_ready();
    m_step();
    #1;
  endtask

  task automatic drive(input bit r, input bit s, input logic [2:0] v,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    reset = r; wb_stall = s; req_valid = v;
    t_rw[0] = a0; t_rw[1] = a1; t_rw[2] = a2;
    t_d[0] = d0;  t_d[1] = d1;  t_d[2] = d2;
  endtask

  typedef struct {
    bit rst; bit stall; logic [2:0] v;
    logic [4:0] a0, a1, a2; logic [31:0] d0, d1, d2;
    logic [2:0] rdy; logic we; logic [4:0] orw; logic [31:0] od; logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, logic [2:0] v, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                              logic [2:0] rdy, logic we, logic [4:0] orw, logic [31:0] od, logic [15:0] cnt);
    vec_t x;
    x.rst = r; x.stall = s; x.v = v; x.a0 = a0; x.a1 = a1; x.a2 = a2;
    x.d0 = d0; x.d1 = d1; x.d2 = d2; x.rdy = rdy; x.we = we; x.orw = orw; x.od = od; x.cnt = cnt;
    return x;
  endfunction

  vec_t tbl [$];
  logic [N-1:0] er;
  bit   p_v [N];

  initial begin
    drive(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, er);
    cyc(0, 0, er);

    //           rst st valid a0 a1 a2  d0   d1   d2     rdy   we rw  data cnt
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,        3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b001, 1, 0, 0, 1234, 0, 0,     3'b001, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,        3'b000, 1, 1, 1234, 0));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,        3'b000, 0, 1, 1234, 1));
    tbl.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0,        3'b000, 0, 1, 1234, 1));
    tbl.push_back(mk(0, 0, 3'b111, 5, 6, 7, 50, 60, 70,     3'b001, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b111, 5, 6, 7, 50, 60, 70,     3'b010, 1, 5, 50, 0));
    tbl.push_back(mk(0, 0, 3'b111, 5, 6, 7, 50, 60, 70,     3'b100, 1, 6, 60, 1));
    tbl.push_back(mk(0, 0, 3'b111, 5, 6, 7, 50, 60, 70,     3'b001, 1, 7, 70, 2));
    tbl.push_back(mk(0, 0, 3'b111, 5, 6, 7, 50, 60, 70,     3'b010, 1, 5, 50, 3));
    tbl.push_back(mk(0, 0, 3'b111, 5, 6, 7, 50, 60, 70,     3'b100, 1, 6, 60, 4));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,        3'b000, 1, 7, 70, 5));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,        3'b000, 0, 7, 70, 6));
    tbl.push_back(mk(0, 0, 3'b010, 0, 13, 0, 0, 99, 0,      3'b010, 0, 7, 70, 6));
    tbl.push_back(mk(0, 1, 3'b101, 3, 0, 4, 33, 0, 44,      3'b000, 1, 13, 99, 6));
    tbl.push_back(mk(0, 1, 3'b101, 3, 0, 4, 33, 0, 44,      3'b000, 1, 13, 99, 6));
    tbl.push_back(mk(0, 1, 3'b101, 3, 0, 4, 33, 0, 44,      3'b000, 1, 13, 99, 6));
    tbl.push_back(mk(0, 0, 3'b101, 3, 0, 4, 33, 0, 44,      3'b100, 1, 13, 99, 6));
    tbl.push_back(mk(0, 0, 3'b001, 3, 0, 0, 33, 0, 0,       3'b001, 1, 4, 44, 7));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,        3'b000, 1, 3, 33, 8));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,        3'b000, 0, 3, 33, 9));
    tbl.push_back(mk(0, 0, 3'b010, 0, 9, 0, 0, 90, 0,       3'b010, 0, 3, 33, 9));
    tbl.push_back(mk(1, 0, 3'b110, 0, 10, 11, 0, 100, 110,  3'b000, 1, 9, 90, 9));
    tbl.push_back(mk(0, 0, 3'b110, 0, 10, 11, 0, 100, 110,  3'b010, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b100, 0, 0, 11, 0, 0, 110,     3'b100, 1, 10, 100, 0));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,        3'b000, 1, 11, 110, 1));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0,        3'b000, 0, 11, 110, 2));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2,
            tbl[i].d0, tbl[i].d1, tbl[i].d2);
      @(negedge clk);
      chk("tbl_ready", i, 32'(req_ready), 32'(tbl[i].rdy));
      chk("tbl_we", i, 32'(RegWrite), 32'(tbl[i].we));
      chk("tbl_rw", i, 32'(RW), 32'(tbl[i].orw));
      chk("tbl_busW", i, busW, tbl[i].od);
      chk("tbl_cnt", i, 32'(wb_count), 32'(tbl[i].cnt));
      @(posedge clk);
      m_step();
      #1;
    end

    // $0 write alongside a real write; pointer is 0, count is 2.
    drive(0, 0, 3'b110, 0, 0, 12, 0, 5, 7);
    @(negedge clk);
    chk("zero_ready", 0, 32'(req_ready), ZD ? 32'b110 : 32'b010);
    @(posedge clk); m_step(); #1;
    if (ZD) begin
      drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("zero_we", 1, 32'(RegWrite), 1);
      chk("zero_rw", 1, 32'(RW), 12);
      chk("zero_busW", 1, busW, 7);
      @(posedge clk); m_step(); #1;
      @(negedge clk);
      chk("zero_cnt", 2, 32'(wb_count), 3);
      @(posedge clk); m_step(); #1;
    end else begin
      drive(0, 0, 3'b100, 0, 0, 12, 0, 0, 7);
      @(negedge clk);
      chk("zero_ready", 1, 32'(req_ready), 32'b100);
      chk("zero_we", 1, 32'(RegWrite), 1);
      chk("zero_rw", 1, 32'(RW), 0);
      chk("zero_busW", 1, busW, 5);
      @(posedge clk); m_step(); #1;
      drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("zero_rw", 2, 32'(RW), 12);
      chk("zero_busW", 2, busW, 7);
      @(posedge clk); m_step(); #1;
      @(negedge clk);
      chk("zero_cnt", 3, 32'(wb_count), 4);
      @(posedge clk); m_step(); #1;
    end

    // Saturation: a sole requester streams one write per cycle.
    drive(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, er);
    drive(0, 0, 3'b001, 1, 0, 0, 32'hABCD, 0, 0);
    for (int c = 0; c < 65537; c++) cyc(0, c, er);
    @(negedge clk);
    chk("sat_cnt", 0, 32'(wb_count), 32'hFFFF);
    chk("sat_model", 0, 32'(wb_count), 32'(m_cnt));
    chk("sat_b2b_ready", 0, 32'(req_ready), 32'b001);
    @(posedge clk); m_step(); #1;
    cyc(0, 0, er);
    cyc(0, 0, er);
    @(negedge clk);
    chk("sat_hold", 1, 32'(wb_count), 32'hFFFF);
    @(posedge clk); m_step(); #1;

    // Randomized traffic honouring the hold-until-accepted rule.
    drive(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, er);
    for (int i = 0; i < N; i++) p_v[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_v[i] && ($urandom % 3 != 0)) begin
          p_v[i] = 1;
          t_rw[i] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          t_d[i] = $urandom;
        end
        req_valid[i] = p_v[i];
      end
      reset = ($urandom % 60 == 0);
      wb_stall = ($urandom % 5 == 0);
      cyc(1, c, er);
      for (int i = 0; i < N; i++) if (er[i]) p_v[i] = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
